// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: register offsets, CTRL/STAT bit positions and the serial FSM
// state encoding shared by the uart_fifo block.
package uart_fifo_pkg;

    localparam logic [31:0] OFF_RXDT = 32'h00;
    localparam logic [31:0] OFF_TXDT = 32'h04;
    localparam logic [31:0] OFF_CTRL = 32'h08;
    localparam logic [31:0] OFF_STAT = 32'h0c;
    localparam logic [31:0] OFF_BAUD = 32'h10;

    localparam int CTRL_RX_EN      = 0;
    localparam int CTRL_TX_EN      = 1;
    localparam int CTRL_RX_FLUSH   = 2;
    localparam int CTRL_TX_FLUSH   = 3;
    localparam int CTRL_PAR_EN     = 4;
    localparam int CTRL_PAR_ODD    = 5;
    localparam int CTRL_IRQ_RX_EN  = 6;
    localparam int CTRL_IRQ_TXE_EN = 7;

    localparam int STAT_OVERRUN    = 4;
    localparam int STAT_FRAME_ERR  = 5;
    localparam int STAT_PARITY_ERR = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Divisors below 3 leave no room for a mid-bit sample, so clamp them.
    function automatic logic [15:0] eff_div(input logic [15:0] baud);
        return (baud < 16'd3) ? 16'd3 : baud;
    endfunction

endpackage

// File: rtl/uart_fifo_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with flush; read-first, so a pop and a push
// in the same cycle both succeed even when the FIFO is full.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: memory-mapped UART with TX/RX FIFOs, sticky errors and level IRQ.
// Define UART_PARITY_EN to build parity generation/checking (CTRL[5:4], STAT[6]).
//   state     | meaning
//   ST_IDLE   | line idle, waiting for start edge (RX) or FIFO data (TX)
//   ST_START  | start bit; RX verifies it at mid-bit
//   ST_DATA   | DATA_BITS data bits, LSB first
//   ST_PARITY | parity bit (parity build only)
//   ST_STOP   | stop bit; RX delivers the byte at mid-bit
module uart_fifo
    import uart_fifo_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hffff0020,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          DATA_BITS   = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
    localparam logic [7:0] CTRL_MASK = 8'hff;
`else
    localparam logic [7:0] CTRL_MASK = 8'hcf;
`endif

    logic hit_rxdt, hit_txdt, hit_ctrl, hit_stat, hit_baud;
    logic [7:0]  ctrl;
    logic [15:0] baud, div;
    logic        sticky_ov, sticky_fe, sticky_pe;
    logic        par_en, par_odd;
    logic [31:0] rd_data;
    logic        unused_bits;

    logic [DATA_BITS-1:0] rx_dout, tx_dout;
    logic                 rx_full, rx_empty, tx_full, tx_empty;
    logic [CW-1:0]        rx_count, tx_count;

    logic                 rx_s1, rx_s2, rx_s3;
    uart_state_t          rx_state, rx_state_nx;
    logic [15:0]          rx_cnt, rx_cnt_nx;
    logic [2:0]           rx_idx, rx_idx_nx;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_nx;
    logic                 rx_par_bad, rx_par_bad_nx;
    logic                 rx_push, rx_fe_set, rx_pe_set, rx_ov_set;

    uart_state_t          tx_state, tx_state_nx;
    logic [15:0]          tx_cnt, tx_cnt_nx;
    logic [2:0]           tx_idx, tx_idx_nx;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_nx;
    logic                 tx_par, tx_par_nx;
    logic                 tx_line_nx, tx_pop, tx_start_ok;

    assign hit_rxdt = (mem_addr == BASE_ADDR + OFF_RXDT);
    assign hit_txdt = (mem_addr == BASE_ADDR + OFF_TXDT);
    assign hit_ctrl = (mem_addr == BASE_ADDR + OFF_CTRL);
    assign hit_stat = (mem_addr == BASE_ADDR + OFF_STAT);
    assign hit_baud = (mem_addr == BASE_ADDR + OFF_BAUD);
    assign div         = eff_div(baud);
    assign unused_bits = &{1'b0, mem_data[31:16]};

`ifdef UART_PARITY_EN
    assign par_en  = ctrl[CTRL_PAR_EN];
    assign par_odd = ctrl[CTRL_PAR_ODD];
`else
    assign par_en  = 1'b0;
    assign par_odd = 1'b0;
`endif

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(mem_we && hit_rxdt),
        .flush(ctrl[CTRL_RX_FLUSH]), .din(rx_shift), .dout(rx_dout),
        .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(mem_we && hit_txdt), .pop(tx_pop),
        .flush(ctrl[CTRL_TX_FLUSH]), .din(mem_data[DATA_BITS-1:0]), .dout(tx_dout),
        .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    always_comb begin
        rd_data = '0;
        if (hit_rxdt) begin
            rd_data[DATA_BITS-1:0] = rx_empty ? '0 : rx_dout;
        end else if (hit_ctrl) begin
            rd_data[7:0] = ctrl;
        end else if (hit_stat) begin
            rd_data = {8'h00, 8'(tx_count), 8'(rx_count), 1'b0, sticky_pe, sticky_fe,
                       sticky_ov, rx_full, tx_full, !tx_empty || (tx_state != ST_IDLE),
                       !rx_empty};
        end else if (hit_baud) begin
            rd_data[15:0] = baud;
        end
    end

    assign mem_data = (rst && !mem_we && (hit_rxdt || hit_ctrl || hit_stat || hit_baud))
                      ? rd_data : 'z;

    assign rx_ov_set = rx_push && rx_full && !(mem_we && hit_rxdt);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl      <= '0;
            baud      <= DEFAULT_DIV;
            sticky_ov <= 1'b0;
            sticky_fe <= 1'b0;
            sticky_pe <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (mem_we && hit_ctrl) ctrl <= mem_data[7:0] & CTRL_MASK;
            else                    ctrl[CTRL_TX_FLUSH:CTRL_RX_FLUSH] <= 2'b00;
            if (mem_we && hit_baud) baud <= mem_data[15:0];
            sticky_ov <= (sticky_ov && !(mem_we && hit_stat && mem_data[STAT_OVERRUN])) || rx_ov_set;
            sticky_fe <= (sticky_fe && !(mem_we && hit_stat && mem_data[STAT_FRAME_ERR])) || rx_fe_set;
            sticky_pe <= (sticky_pe && !(mem_we && hit_stat && mem_data[STAT_PARITY_ERR])) || rx_pe_set;
            irq <= (ctrl[CTRL_IRQ_RX_EN] && !rx_empty) ||
                   (ctrl[CTRL_IRQ_TXE_EN] && tx_empty && (tx_state == ST_IDLE));
        end
    end

    always_comb begin
        rx_state_nx   = rx_state;
        rx_cnt_nx     = rx_cnt;
        rx_idx_nx     = rx_idx;
        rx_shift_nx   = rx_shift;
        rx_par_bad_nx = rx_par_bad;
        rx_push       = 1'b0;
        rx_fe_set     = 1'b0;
        rx_pe_set     = 1'b0;
        if (rx_cnt != '0) rx_cnt_nx = rx_cnt - 1'b1;
        case (rx_state)
            ST_IDLE: if (rx_s3 && !rx_s2) begin
                rx_state_nx = ST_START;
                rx_cnt_nx   = div >> 1;
            end
            ST_START: if (rx_cnt == '0) begin
                rx_state_nx   = rx_s2 ? ST_IDLE : ST_DATA;
                rx_cnt_nx     = div;
                rx_idx_nx     = '0;
                rx_par_bad_nx = 1'b0;
            end
            ST_DATA: if (rx_cnt == '0) begin
                rx_shift_nx = {rx_s2, rx_shift[DATA_BITS-1:1]};
                rx_cnt_nx   = div;
                rx_idx_nx   = rx_idx + 1'b1;
                if (rx_idx == LAST_BIT) rx_state_nx = par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (rx_cnt == '0) begin
                rx_par_bad_nx = ^rx_shift ^ rx_s2 ^ par_odd;
                rx_state_nx   = ST_STOP;
                rx_cnt_nx     = div;
            end
            ST_STOP: if (rx_cnt == '0) begin
                rx_state_nx = ST_IDLE;
                if (!rx_s2)          rx_fe_set = 1'b1;
                else if (rx_par_bad) rx_pe_set = 1'b1;
                else                 rx_push   = 1'b1;
            end
            default: rx_state_nx = ST_IDLE;
        endcase
        if (!ctrl[CTRL_RX_EN]) begin
            rx_state_nx = ST_IDLE;
            rx_push     = 1'b0;
            rx_fe_set   = 1'b0;
            rx_pe_set   = 1'b0;
        end
    end

    // A pending flush blocks the pop so the flushed head is not transmitted.
    assign tx_start_ok = ctrl[CTRL_TX_EN] && !tx_empty && !ctrl[CTRL_TX_FLUSH];

    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_idx_nx   = tx_idx;
        tx_shift_nx = tx_shift;
        tx_par_nx   = tx_par;
        tx_pop      = 1'b0;
        if (tx_cnt != '0) tx_cnt_nx = tx_cnt - 1'b1;
        case (tx_state)
            ST_IDLE: tx_pop = tx_start_ok;
            ST_START: if (tx_cnt == '0) begin
                tx_state_nx = ST_DATA;
                tx_cnt_nx   = div;
                tx_idx_nx   = '0;
            end
            ST_DATA: if (tx_cnt == '0) begin
                tx_cnt_nx = div;
                if (tx_idx == LAST_BIT) begin
                    tx_state_nx = par_en ? ST_PARITY : ST_STOP;
                end else begin
                    tx_idx_nx   = tx_idx + 1'b1;
                    tx_shift_nx = tx_shift >> 1;
                end
            end
            ST_PARITY: if (tx_cnt == '0) begin
                tx_state_nx = ST_STOP;
                tx_cnt_nx   = div;
            end
            ST_STOP: if (tx_cnt == '0) begin
                tx_state_nx = ST_IDLE;
                tx_pop      = tx_start_ok;
            end
            default: tx_state_nx = ST_IDLE;
        endcase
        if (tx_pop) begin
            tx_state_nx = ST_START;
            tx_cnt_nx   = div;
            tx_shift_nx = tx_dout;
            tx_par_nx   = ^tx_dout ^ par_odd;
        end
        case (tx_state_nx)
            ST_START:  tx_line_nx = 1'b0;
            ST_DATA:   tx_line_nx = tx_shift_nx[0];
            ST_PARITY: tx_line_nx = tx_par_nx;
            default:   tx_line_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_s3      <= 1'b1;
            rx_state   <= ST_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_par_bad <= 1'b0;
            tx_state   <= ST_IDLE;
            tx_cnt     <= '0;
            tx_idx     <= '0;
            tx_shift   <= '0;
            tx_par     <= 1'b0;
            uart_tx    <= 1'b1;
        end else begin
            rx_s1      <= uart_rx;
            rx_s2      <= rx_s1;
            rx_s3      <= rx_s2;
            rx_state   <= rx_state_nx;
            rx_cnt     <= rx_cnt_nx;
            rx_idx     <= rx_idx_nx;
            rx_shift   <= rx_shift_nx;
            rx_par_bad <= rx_par_bad_nx;
            tx_state   <= tx_state_nx;
            tx_cnt     <= tx_cnt_nx;
            tx_idx     <= tx_idx_nx;
            tx_shift   <= tx_shift_nx;
            tx_par     <= tx_par_nx;
            uart_tx    <= tx_line_nx;
        end
    end

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed checks of the uart_fifo register block, TX/RX framing,
// FIFO limits, sticky errors, IRQ timing and reset. Parity cases need UART_PARITY_EN.
module tb_uart_fifo;

    localparam logic [31:0] BASE = 32'hffff0020;
    localparam logic [31:0] RXDT = 32'h00;
    localparam logic [31:0] TXDT = 32'h04;
    localparam logic [31:0] CTRL = 32'h08;
    localparam logic [31:0] STAT = 32'h0c;
    localparam logic [31:0] BAUD = 32'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] bus_wdata = 32'h0;
    wire  [31:0] mem_data;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        irq;

    int nvec = 0;
    int nerr = 0;
    logic tr     [0:1299];
    logic irq_tr [0:1299];

    assign mem_data = mem_we ? bus_wdata : 'z;

    uart_fifo dut (
        .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] off, input logic [31:0] d);
        @(posedge clk); #1;
        mem_we = 1'b1; mem_addr = BASE + off; bus_wdata = d;
        @(posedge clk); #1;
        mem_we = 1'b0; mem_addr = 32'h0;
    endtask

    task automatic bus_rd(input logic [31:0] off, output logic [31:0] d);
        @(negedge clk);
        mem_addr = BASE + off;
        #1 d = mem_data;
        mem_addr = 32'h0;
    endtask

    task automatic wait_tx_low(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (uart_tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            tr[i] = uart_tx;
            irq_tr[i] = irq;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input logic with_par,
                           input logic par);
        uart_rx = 1'b0; wait_clks(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i]; wait_clks(16);
        end
        if (with_par) begin
            uart_rx = par; wait_clks(16);
        end
        uart_rx = stop; wait_clks(16);
        uart_rx = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        wait_clks(3);
        nvec++;
        if (uart_tx !== 1'b1 || irq !== 1'b0) begin
            nerr++; $display("FAIL reset_outputs: uart_tx=%b irq=%b expected 1 0", uart_tx, irq);
        end
        rst = 1'b1;
        wait_clks(1);
        bus_rd(CTRL, d); nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL reset_ctrl: got %h expected 0", d); end
        bus_rd(BAUD, d); nvec++;
        if (d !== 32'd433) begin nerr++; $display("FAIL reset_baud: got %h expected %h", d, 32'd433); end
        bus_rd(STAT, d); nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL reset_stat: got %h expected 0", d); end
        bus_rd(RXDT, d); nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL reset_rxdt: got %h expected 0", d); end
    endtask

    task automatic test_tx_basic;
        bit found;
        logic [175:0] act, exp;
        bus_wr(BAUD, 32'd15);
        bus_wr(CTRL, 32'h3);
        bus_wr(TXDT, 32'h55);
        wait_tx_low(40, found);
        nvec++;
        if (!found) begin
            nerr++; $display("FAIL tx_start_timeout: uart_tx stayed %b expected 0", uart_tx);
        end else begin
            capture(176);
            for (int i = 0; i < 176; i++) begin
                act[i] = tr[i];
                if (i < 16)       exp[i] = 1'b0;
                else if (i < 144) exp[i] = (8'h55 >> ((i - 16) / 16)) & 8'h1;
                else              exp[i] = 1'b1;
            end
            if (act !== exp) begin
                nerr++; $display("FAIL tx_wave_55: got %h expected %h", act, exp);
            end
        end
    endtask

    task automatic test_rx_basic;
        logic [31:0] d;
        send_rx(8'hA3, 1'b1, 1'b0, 1'b0);
        wait_clks(4);
        bus_rd(STAT, d); nvec++;
        if (d !== 32'h0000_0101) begin nerr++; $display("FAIL rx_stat: got %h expected 00000101", d); end
        bus_rd(RXDT, d); nvec++;
        if (d !== 32'hA3) begin nerr++; $display("FAIL rx_data: got %h expected a3", d); end
        bus_wr(RXDT, 32'h0);
        bus_rd(STAT, d); nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL rx_pop_stat: got %h expected 0", d); end
    endtask

    task automatic test_rx_overrun;
        logic [31:0] d;
        for (int k = 0; k < 9; k++) send_rx(8'h10 + 8'(k), 1'b1, 1'b0, 1'b0);
        wait_clks(4);
        bus_rd(STAT, d); nvec++;
        if (d !== 32'h0000_0819) begin nerr++; $display("FAIL ovr_stat: got %h expected 00000819", d); end
        bus_wr(STAT, 32'h10);
        bus_rd(STAT, d); nvec++;
        if (d !== 32'h0000_0809) begin nerr++; $display("FAIL ovr_w1c: got %h expected 00000809", d); end
        for (int k = 0; k < 8; k++) begin
            bus_rd(RXDT, d); nvec++;
            if (d !== 32'h10 + k) begin
                nerr++; $display("FAIL ovr_byte%0d: got %h expected %h", k, d, 32'h10 + k);
            end
            bus_wr(RXDT, 32'h0);
        end
        bus_rd(STAT, d); nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL ovr_drain: got %h expected 0", d); end
    endtask

    task automatic test_rx_errors;
        logic [31:0] d;
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
        wait_clks(20);
        bus_rd(STAT, d); nvec++;
        if (d !== 32'h20) begin nerr++; $display("FAIL frame_err: got %h expected 00000020", d); end
        bus_wr(STAT, 32'h20);
        bus_rd(STAT, d); nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL frame_w1c: got %h expected 0", d); end
        uart_rx = 1'b0; wait_clks(2);
        uart_rx = 1'b1; wait_clks(40);
        bus_rd(STAT, d); nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL glitch_stat: got %h expected 0", d); end
        bus_rd(RXDT, d); nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL glitch_rxdt: got %h expected 0", d); end
    endtask

    task automatic test_ctrl_flush;
        logic [31:0] d;
        bus_wr(CTRL, 32'h0);
        for (int k = 0; k < 3; k++) bus_wr(TXDT, 32'hA0 + k);
        bus_rd(STAT, d); nvec++;
        if (d !== 32'h0003_0002) begin nerr++; $display("FAIL flush_pre: got %h expected 00030002", d); end
        bus_wr(CTRL, 32'h08);
        wait_clks(2);
        bus_rd(STAT, d); nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL flush_stat: got %h expected 0", d); end
        bus_rd(CTRL, d); nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL flush_selfclear: got %h expected 0", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic [9:0]  act, exp;
        bit found;
        for (int k = 0; k < 10; k++) bus_wr(TXDT, 32'h30 + k);
        bus_rd(STAT, d); nvec++;
        if (d !== 32'h0008_0006) begin nerr++; $display("FAIL txfull_stat: got %h expected 00080006", d); end
        nvec++;
        if (irq !== 1'b0) begin nerr++; $display("FAIL txfull_irq: got %b expected 0", irq); end
        bus_wr(CTRL, 32'h82);
        wait_tx_low(40, found);
        nvec++;
        if (!found) begin
            nerr++; $display("FAIL b2b_start_timeout: uart_tx stayed %b expected 0", uart_tx);
        end else begin
            capture(1300);
            for (int k = 0; k < 8; k++) begin
                for (int j = 0; j < 10; j++) act[j] = tr[160 * k + 8 + 16 * j];
                exp = {1'b1, 8'h30 + 8'(k), 1'b0};
                nvec++;
                if (act !== exp) begin
                    nerr++; $display("FAIL b2b_frame%0d: got %h expected %h", k, act, exp);
                end
            end
            nvec++;
            if (irq_tr[1200] !== 1'b0 || irq_tr[1280] !== 1'b0) begin
                nerr++; $display("FAIL b2b_irq_early: got %b%b expected 00", irq_tr[1200], irq_tr[1280]);
            end
            nvec++;
            if (irq_tr[1281] !== 1'b1 || tr[1290] !== 1'b1) begin
                nerr++; $display("FAIL b2b_irq_done: irq=%b line=%b expected 1 1", irq_tr[1281], tr[1290]);
            end
        end
    endtask

    task automatic test_baud_clamp;
        logic [31:0] d;
        logic [43:0] act, exp;
        bit found;
        bus_wr(BAUD, 32'd0);
        bus_rd(BAUD, d); nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL baud_readback: got %h expected 0", d); end
        bus_wr(CTRL, 32'h2);
        bus_wr(TXDT, 32'hF0);
        wait_tx_low(40, found);
        nvec++;
        if (!found) begin
            nerr++; $display("FAIL clamp_start_timeout: uart_tx stayed %b expected 0", uart_tx);
        end else begin
            capture(44);
            exp = {4'hF, 4'hF, 16'hFFFF, 16'h0000, 4'h0};
            for (int i = 0; i < 44; i++) act[i] = tr[i];
            if (act !== exp) begin nerr++; $display("FAIL clamp_wave: got %h expected %h", act, exp); end
        end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity;
        logic [31:0]  d;
        logic [191:0] act, exp;
        bit found;
        bus_wr(BAUD, 32'd15);
        bus_wr(CTRL, 32'h13);
        bus_rd(CTRL, d); nvec++;
        if (d !== 32'h13) begin nerr++; $display("FAIL par_ctrl: got %h expected 13", d); end
        bus_wr(TXDT, 32'h07);
        wait_tx_low(40, found);
        nvec++;
        if (!found) begin
            nerr++; $display("FAIL par_start_timeout: uart_tx stayed %b expected 0", uart_tx);
        end else begin
            capture(192);
            for (int i = 0; i < 192; i++) begin
                act[i] = tr[i];
                if (i < 16)       exp[i] = 1'b0;
                else if (i < 144) exp[i] = (8'h07 >> ((i - 16) / 16)) & 8'h1;
                else              exp[i] = 1'b1;
            end
            if (act !== exp) begin nerr++; $display("FAIL par_tx_wave: got %h expected %h", act, exp); end
        end
        send_rx(8'h07, 1'b1, 1'b1, 1'b0);
        wait_clks(4);
        bus_rd(STAT, d); nvec++;
        if (d !== 32'h40) begin nerr++; $display("FAIL par_bad_stat: got %h expected 00000040", d); end
        bus_wr(STAT, 32'h40);
        send_rx(8'h07, 1'b1, 1'b1, 1'b1);
        wait_clks(4);
        bus_rd(RXDT, d); nvec++;
        if (d !== 32'h07) begin nerr++; $display("FAIL par_good_data: got %h expected 07", d); end
        bus_wr(RXDT, 32'h0);
    endtask
`endif

    task automatic test_reset_mid_frame;
        logic [31:0] d;
        bit found;
        bus_wr(BAUD, 32'd15);
        bus_wr(CTRL, 32'h2);
        bus_wr(TXDT, 32'h00);
        bus_wr(TXDT, 32'h00);
        wait_tx_low(40, found);
        wait_clks(20);
        nvec++;
        if (uart_tx !== 1'b0) begin nerr++; $display("FAIL midrst_pre: uart_tx=%b expected 0", uart_tx); end
        rst = 1'b0;
        wait_clks(1);
        nvec++;
        if (uart_tx !== 1'b1) begin nerr++; $display("FAIL midrst_line: uart_tx=%b expected 1", uart_tx); end
        rst = 1'b1;
        bus_rd(STAT, d); nvec++;
        if (d !== 32'h0) begin nerr++; $display("FAIL midrst_stat: got %h expected 0", d); end
        bus_rd(BAUD, d); nvec++;
        if (d !== 32'd433) begin nerr++; $display("FAIL midrst_baud: got %h expected %h", d, 32'd433); end
        wait_clks(40);
        nvec++;
        if (uart_tx !== 1'b1) begin nerr++; $display("FAIL midrst_idle: uart_tx=%b expected 1", uart_tx); end
    endtask

    initial begin
        test_reset;
        test_tx_basic;
        test_rx_basic;
        test_rx_overrun;
        test_rx_errors;
        test_ctrl_flush;
        test_back_to_back;
        test_baud_clamp;
`ifdef UART_PARITY_EN
        test_parity;
`endif
        test_reset_mid_frame;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
